// File: rtl/conv2_maxpool_relu.sv
// 2x2/stride-2 max pool + ReLU + 12-bit saturation over three lockstep conv2 channels, half-row buffered.
// Result registered one cycle after the bottom-right window sample; no backpressure, consumer must take every strobe.
module conv2_maxpool_relu #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 12,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic signed [IN_W-1:0]  conv_in_1,
  input  logic signed [IN_W-1:0]  conv_in_2,
  input  logic signed [IN_W-1:0]  conv_in_3,
  output logic signed [OUT_W-1:0] pool_out_1,
  output logic signed [OUT_W-1:0] pool_out_2,
  output logic signed [OUT_W-1:0] pool_out_3,
  output logic                    valid_out,
  output logic                    frame_done
);

  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int HALF = IMG_W / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t                  state;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic [BW-1:0]           idx;
  logic                    last_col;
  logic                    last_row;
  logic signed [IN_W-1:0]  din      [3];
  logic signed [IN_W-1:0]  h        [3];
  logic signed [IN_W-1:0]  m        [3];
  logic signed [IN_W-1:0]  bufv     [3];
  logic signed [IN_W-1:0]  p        [3];
  logic signed [OUT_W-1:0] res      [3];
  logic signed [OUT_W-1:0] pool_q   [3];
  logic signed [IN_W-1:0]  half_row [3][HALF];

  assign din[0]   = conv_in_1;
  assign din[1]   = conv_in_2;
  assign din[2]   = conv_in_3;
  assign idx      = BW'(col >> 1);
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));

  // Horizontal pair max, then vertical max against the pair stored from the even row.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      m[c]    = (din[c] > h[c]) ? din[c] : h[c];
      bufv[c] = half_row[c][idx];
      p[c]    = (bufv[c] > m[c]) ? bufv[c] : m[c];
      if (p[c] < 0)
        res[c] = '0;
      else if (p[c] > SAT_MAX)
        res[c] = SAT_MAX[OUT_W-1:0];
      else
        res[c] = p[c][OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      state      <= FILL;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        h[c]      <= '0;
        pool_q[c] <= '0;
      end
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (last_col) begin
          col   <= '0;
          row   <= last_row ? '0 : row + 1'b1;
          state <= (state == FILL) ? EMIT : FILL;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          for (int c = 0; c < 3; c++) h[c] <= din[c];
        end else if (state == EMIT) begin
          for (int c = 0; c < 3; c++) pool_q[c] <= res[c];
          valid_out  <= 1'b1;
          frame_done <= last_row && last_col;
        end
      end
    end
  end

  // Contents are don't-care after reset: every entry is rewritten in FILL before EMIT reads it.
  always_ff @(posedge clk) begin
    if (valid_in && col[0] && state == FILL) begin
      for (int c = 0; c < 3; c++) half_row[c][idx] <= m[c];
    end
  end

  assign pool_out_1 = pool_q[0];
  assign pool_out_2 = pool_q[1];
  assign pool_out_3 = pool_q[2];

endmodule

// File: tb/tb_conv2_maxpool_relu.sv
// Directed frames for conv2_maxpool_relu; expected windows queued at issue time, checked by an output monitor.
module tb_conv2_maxpool_relu;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid_in = 1'b0;
  logic signed [13:0] c1 = '0, c2 = '0, c3 = '0;
  logic signed [11:0] o1, o2, o3;
  logic               vo, fd;

  conv2_maxpool_relu dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .conv_in_1(c1), .conv_in_2(c2), .conv_in_3(c3),
    .pool_out_1(o1), .pool_out_2(o2), .pool_out_3(o3),
    .valid_out(vo), .frame_done(fd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int e1, e2, e3;
    bit fd;
    int stamp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  int ramp[16] = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};
  int shft[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 5, 7, 17, 19, 21, 23};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per strobe; also flags stray strobes.
  always @(negedge clk) begin
    if (vo) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid_out: got valid_out=1 expected no output (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("pool_out_1", int'(o1), e.e1);
        chk("pool_out_2", int'(o2), e.e2);
        chk("pool_out_3", int'(o3), e.e3);
        chk("frame_done", int'(fd), int'(e.fd));
        chk("latency_cycle", cyc, e.stamp);
      end
    end else begin
      chk("frame_done_idle", int'(fd), 0);
    end
  end

  // kind 0: ramp / ReLU / saturation; kind 1: shifted ramp / saturation boundary / all -1.
  task automatic gen(input int kind, input int r, input int c, output int a, output int b, output int d);
    if (kind == 0) begin
      a = r * 8 + c;
      b = (r == 1 && c == 1) ? 5 : -100;
      d = (r == 0 && c == 0) ? 8191 : -8192;
    end else begin
      a = r * 8 + c - 40;
      b = (c < 4) ? 2046 : 2048;
      d = -1;
    end
  endtask

  task automatic send_frame(input int kind, input int maxgap, input int nsamp);
    int a, b, d, r, c, w, gaps;
    exp_t x;
    for (int s = 0; s < nsamp; s++) begin
      r = s / 8;
      c = s % 8;
      gaps = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      repeat (gaps) begin
        @(negedge clk);
        valid_in = 1'b0;
      end
      @(negedge clk);
      gen(kind, r, c, a, b, d);
      valid_in = 1'b1;
      c1 = 14'(a);
      c2 = 14'(b);
      c3 = 14'(d);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        w = (r / 2) * 4 + c / 2;
        if (kind == 0) begin
          x.e1 = ramp[w];
          x.e2 = (w == 0) ? 5 : 0;
          x.e3 = (w == 0) ? 2047 : 0;
        end else begin
          x.e1 = shft[w];
          x.e2 = (w % 4 < 2) ? 2046 : 2047;
          x.e3 = 0;
        end
        x.fd    = (r == 7 && c == 7);
        x.stamp = cyc + 1;
        q.push_back(x);
      end
    end
  endtask

  task automatic hold_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst      = 1'b1;
      valid_in = 1'b1;
      c1 = 14'($urandom);
      c2 = 14'($urandom);
      c3 = 14'($urandom);
    end
    chk("reset_pool_out_1", int'(o1), 0);
    chk("reset_pool_out_2", int'(o2), 0);
    chk("reset_pool_out_3", int'(o3), 0);
    chk("reset_valid_out", int'(vo), 0);
    chk("reset_frame_done", int'(fd), 0);
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit with %0d outputs pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    hold_reset(6);
    send_frame(0, 0, 64);
    send_frame(1, 0, 64);
    send_frame(0, 0, 20);
    hold_reset(3);
    send_frame(0, 3, 64);
    send_frame(0, 0, 64);
    @(negedge clk);
    valid_in = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending_outputs", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
